// File: rtl/router_pkt_tx_if.sv
// Host/router-side signal bundle for router_pkt_tx.
// corrupt_parity exists only when PKT_TX_PARITY_CORRUPT_EN is defined.
interface router_pkt_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6
);
  logic                  wr_en;
  logic [LEN_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic [1:0]            dest_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  abort;
  logic                  busy;
`ifdef PKT_TX_PARITY_CORRUPT_EN
  logic                  corrupt_parity;
`endif
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  tx_active;
  logic                  done;
  logic                  cmd_err;

  modport master (
`ifdef PKT_TX_PARITY_CORRUPT_EN
    output corrupt_parity,
`endif
    output wr_en, wr_addr, wr_data, start, dest_addr, length, abort, busy,
    input  pkt_valid, data_out, tx_active, done, cmd_err
  );

  modport slave (
`ifdef PKT_TX_PARITY_CORRUPT_EN
    input  corrupt_parity,
`endif
    input  wr_en, wr_addr, wr_data, start, dest_addr, length, abort, busy,
    output pkt_valid, data_out, tx_active, done, cmd_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input: header, buffered payload, parity byte.
// Optional macro PKT_TX_PARITY_CORRUPT_EN adds corrupt_parity (inverted parity byte).
module router_pkt_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_tx_if.slave bus
);
  localparam int                   DEPTH = 2 ** LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] ONE   = LEN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY} state_t;

  state_t                r_state, w_state;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_out;
  logic                  r_pkt_valid, w_pkt_valid;
  logic                  r_done, w_done;
  logic                  r_cmd_err, w_cmd_err;
  logic                  r_tx_active;
  logic [DATA_WIDTH-1:0] r_parity, w_parity;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt;
  logic [LEN_WIDTH-1:0]  r_len, w_len;
  logic                  r_corrupt, w_corrupt;

  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic [LEN_WIDTH-1:0]  w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_par_out;

  // NOTE: the payload buffer is left out of reset on purpose; clearing a RAM
  // costs a write port per entry and the host always loads it before use.
  always_ff @(posedge clk) begin
    if (bus.wr_en && r_state == S_IDLE)
      r_buf[bus.wr_addr] <= bus.wr_data;
  end

  // Buffer is frozen outside IDLE, so an async read of the next index is the
  // prefetch: the following byte is ready on the same edge the current one goes.
  assign w_rd_idx  = (r_state == S_PAYLOAD) ? r_cnt + ONE : '0;
  assign w_rd_data = r_buf[w_rd_idx];

`ifdef PKT_TX_PARITY_CORRUPT_EN
  assign w_par_out = r_corrupt ? ~r_parity : r_parity;
`else
  assign w_par_out = r_parity;
`endif

  // NOTE: every next-state signal gets its hold value first so that no path
  // through the case statement can infer a latch.
  always_comb begin
    w_state     = r_state;
    w_data_out  = r_data_out;
    w_pkt_valid = r_pkt_valid;
    w_done      = 1'b0;
    w_cmd_err   = 1'b0;
    w_parity    = r_parity;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_corrupt   = r_corrupt;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dest_addr == 2'd3 || bus.length == '0) begin
            w_cmd_err = 1'b1;
          end else begin
            w_state     = S_HEADER;
            w_len       = bus.length;
            w_data_out  = {bus.length, bus.dest_addr};
            w_pkt_valid = 1'b1;
            w_parity    = {bus.length, bus.dest_addr};
`ifdef PKT_TX_PARITY_CORRUPT_EN
            w_corrupt   = bus.corrupt_parity;
`else
            w_corrupt   = 1'b0;
`endif
          end
        end
      end
      S_HEADER: begin
        if (!bus.busy) begin
          w_state    = S_PAYLOAD;
          w_cnt      = '0;
          w_data_out = w_rd_data;
          w_parity   = r_parity ^ w_rd_data;
        end
      end
      S_PAYLOAD: begin
        if (!bus.busy) begin
          if (r_cnt == r_len - ONE) begin
            w_state     = S_PARITY;
            w_pkt_valid = 1'b0;
            w_data_out  = w_par_out;
          end else begin
            w_cnt      = r_cnt + ONE;
            w_data_out = w_rd_data;
            w_parity   = r_parity ^ w_rd_data;
          end
        end
      end
      S_PARITY: begin
        if (!bus.busy) begin
          w_state    = S_IDLE;
          w_done     = 1'b1;
          w_data_out = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Abort overrides whatever the active state decided, including an accept.
    if (r_state != S_IDLE && bus.abort) begin
      w_state     = S_IDLE;
      w_pkt_valid = 1'b0;
      w_data_out  = '0;
      w_done      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_data_out  <= '0;
      r_pkt_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_tx_active <= 1'b0;
      r_parity    <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_corrupt   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_data_out  <= w_data_out;
      r_pkt_valid <= w_pkt_valid;
      r_done      <= w_done;
      r_cmd_err   <= w_cmd_err;
      r_tx_active <= (w_state != S_IDLE);
      r_parity    <= w_parity;
      r_cnt       <= w_cnt;
      r_len       <= w_len;
      r_corrupt   <= w_corrupt;
    end
  end

  assign bus.pkt_valid = r_pkt_valid;
  assign bus.data_out  = r_data_out;
  assign bus.tx_active = r_tx_active;
  assign bus.done      = r_done;
  assign bus.cmd_err   = r_cmd_err;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx: vector table plus hand-written
// sequences for the maximum-length packet and mid-packet reset.
module tb_router_pkt_tx;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

`ifdef PKT_TX_PARITY_CORRUPT_EN
  localparam logic [7:0] P1 = 8'h22;
`else
  localparam logic [7:0] P1 = 8'hDD;
`endif

  router_pkt_tx_if #(.DATA_WIDTH(8), .LEN_WIDTH(6)) bus ();

  router_pkt_tx #(.DATA_WIDTH(8), .LEN_WIDTH(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [5:0] wa;
    logic [7:0] wd;
    logic       st;
    logic [1:0] dst;
    logic [5:0] len;
    logic       ab;
    logic       by;
    logic       cp;
    logic       e_pv;
    logic [7:0] e_d;
    logic       e_tx;
    logic       e_dn;
    logic       e_er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                              input logic st, input logic [1:0] dst, input logic [5:0] len,
                              input logic ab, input logic by, input logic cp,
                              input logic e_pv, input logic [7:0] e_d, input logic e_tx,
                              input logic e_dn, input logic e_er);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.dst = dst; v.len = len;
    v.ab = ab; v.by = by; v.cp = cp;
    v.e_pv = e_pv; v.e_d = e_d; v.e_tx = e_tx; v.e_dn = e_dn; v.e_er = e_er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.wr_en     = v.we;
    bus.wr_addr   = v.wa;
    bus.wr_data   = v.wd;
    bus.start     = v.st;
    bus.dest_addr = v.dst;
    bus.length    = v.len;
    bus.abort     = v.ab;
    bus.busy      = v.by;
`ifdef PKT_TX_PARITY_CORRUPT_EN
    bus.corrupt_parity = v.cp;
`endif
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic pv, input logic [7:0] d,
                            input logic tx, input logic dn, input logic er);
    check({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'(pv));
    check({tag, ".data_out"},  32'(bus.data_out),  32'(d));
    check({tag, ".tx_active"}, 32'(bus.tx_active), 32'(tx));
    check({tag, ".done"},      32'(bus.done),      32'(dn));
    check({tag, ".cmd_err"},   32'(bus.cmd_err),   32'(er));
  endtask

  initial begin
    // Basic packet A1,B2,C3 to port 1 (corrupt_parity requested), back-to-back
    tbl.push_back(mk(1, 0, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'hB2, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 2, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 1, 3, 0, 0, 1, 1, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hA1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hB2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hC3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, P1,    1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));
    // Same packet, busy holds B2 for 4 cycles; stray wr_en/start are ignored
    tbl.push_back(mk(0, 0, 0,     1, 1, 3, 0, 0, 0, 1, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hA1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hB2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFF, 1, 3, 5, 0, 1, 0, 1, 8'hB2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0, 1, 8'hB2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0, 1, 8'hB2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hC3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'hDD, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));
    // Rejected starts, and abort in IDLE
    tbl.push_back(mk(0, 0, 0,     1, 3, 5, 0, 0, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    // Abort during payload wins over accept; then 1-byte packet with same-edge write
    tbl.push_back(mk(0, 0, 0,     1, 1, 3, 0, 0, 0, 1, 8'h0D, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hA1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'hB2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h5A, 1, 2, 1, 0, 0, 0, 1, 8'h06, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 8'h5A, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));

    // Reset values
    idle();
    resetn = 1'b0;
    step();
    step();
    check_outs("reset", 0, 8'h00, 0, 0, 0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      step();
      check_outs($sformatf("vec%0d", i), tbl[i].e_pv, tbl[i].e_d, tbl[i].e_tx,
                 tbl[i].e_dn, tbl[i].e_er);
    end

    // Maximum length: buf[i]=i, 63 payload bytes to port 2
    for (int i = 0; i < 64; i++) begin
      apply(mk(1, 6'(i), 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
    end
    apply(mk(0, 0, 0, 1, 2, 63, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check_outs("max.hdr", 1, 8'hFE, 1, 0, 0);
    idle();
    for (int i = 0; i < 63; i++) begin
      step();
      check($sformatf("max.pl%0d.data", i), 32'(bus.data_out), 32'(i));
      check($sformatf("max.pl%0d.pv", i), 32'(bus.pkt_valid), 32'd1);
    end
    step();
    check_outs("max.par", 0, 8'hC1, 1, 0, 0);
    step();
    check_outs("max.done", 0, 8'h00, 0, 1, 0);

    // Mid-packet reset; buffer survives reset
    apply(mk(1, 0, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    apply(mk(0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check_outs("rst.hdr", 1, 8'h08, 1, 0, 0);
    idle();
    step();
    check_outs("rst.pl0", 1, 8'h3C, 1, 0, 0);
    resetn = 1'b0;
    step();
    check_outs("rst.mid", 0, 8'h00, 0, 0, 0);
    resetn = 1'b1;
    step();
    check_outs("rst.idle", 0, 8'h00, 0, 0, 0);
    apply(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check_outs("post.hdr", 1, 8'h05, 1, 0, 0);
    idle();
    step();
    check_outs("post.pl0", 1, 8'h3C, 1, 0, 0);
    step();
    check_outs("post.par", 0, 8'h39, 1, 0, 0);
    step();
    check_outs("post.done", 0, 8'h00, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
